// File: rtl/canvas_painter_pkg.sv
// Shared types and constants for the canvas painter: canvas size, ink levels,
// FSM state encoding and the 5-bit cell coordinate type.
package canvas_painter_pkg;
    localparam int          CANVAS_N = 28;
    localparam logic [15:0] INK      = 16'h07F8;
    localparam logic [15:0] SPREAD   = 16'h0200;

    typedef logic [4:0] cell_t;

    localparam cell_t CELL_MAX = 5'(CANVAS_N - 1);

    typedef enum logic [2:0] {
        IDLE,
        PAINT_C,
        PAINT_N,
        CLEAR,
        STREAM
    } state_e;
endpackage

// File: rtl/canvas_painter_pix_to_cell.sv
// Maps one pixel coordinate axis onto a canvas cell index and flags whether
// the pixel lies on the canvas. Pixels left of / above the origin never wrap.
module pix_to_cell
    import canvas_painter_pkg::*;
#(
    parameter int CELL_PX = 14,
    parameter int ORIGIN  = 199
) (
    input  logic [9:0] pix_i,
    output cell_t      cell_o,
    output logic       inside_o
);
    logic [9:0] offset;
    logic [9:0] quot;

    assign offset   = pix_i - 10'(ORIGIN);
    assign quot     = offset / 10'(CELL_PX);
    assign inside_o = (pix_i >= 10'(ORIGIN)) && (quot < 10'(CANVAS_N));
    assign cell_o   = quot[4:0];
endmodule

// File: rtl/canvas_painter.sv
// Paints ink into a 28x28 canvas under a pen cursor, clears it column by column
// and streams it out row-major over a valid/ready handshake.
module canvas_painter
    import canvas_painter_pkg::*;
#(
    parameter int CELL_PX  = 14,
    parameter int ORIGIN_X = 199,
    parameter int ORIGIN_Y = 43
) (
    input  logic                                        Clk,
    input  logic                                        Reset_n,
    input  logic [9:0]                                  BallX,
    input  logic [9:0]                                  BallY,
    input  logic                                        Draw,
    input  logic                                        Clear,
    input  logic                                        Stream_start,
    input  logic                                        Pix_ready,
    output logic [CANVAS_N-1:0][CANVAS_N-1:0][15:0]     canvas,
    output logic [15:0]                                 Pix_data,
    output logic                                        Pix_valid,
    output logic                                        Pix_last,
    output logic                                        Busy
);
    state_e state_q, state_d;
    cell_t  cnt_q, cnt_d;
    cell_t  cx_q, cx_d, cy_q, cy_d;
    cell_t  last_x_q, last_x_d, last_y_q, last_y_d;
    cell_t  sx_q, sx_d, sy_q, sy_d;
    logic   last_vld_q, last_vld_d;
    logic   clr_pend_q, clr_pend_d;
    logic   draw_prev_q;
    logic [CANVAS_N-1:0][CANVAS_N-1:0][15:0] canvas_q;

    cell_t       cur_x, cur_y;
    logic        in_x, in_y, paint_go;
    logic        we, nb_ok, clr_col;
    cell_t       wr_x, wr_y;
    logic [15:0] wr_data;

    function automatic logic [15:0] sat_spread(input logic [15:0] v);
        logic [16:0] s;
        s = {1'b0, v} + {1'b0, SPREAD};
        return (s > {1'b0, INK}) ? INK : s[15:0];
    endfunction

    pix_to_cell #(.CELL_PX(CELL_PX), .ORIGIN(ORIGIN_X)) u_cell_x (
        .pix_i(BallX), .cell_o(cur_x), .inside_o(in_x)
    );
    pix_to_cell #(.CELL_PX(CELL_PX), .ORIGIN(ORIGIN_Y)) u_cell_y (
        .pix_i(BallY), .cell_o(cur_y), .inside_o(in_y)
    );

    // A held pen repaints only when it moves to a new cell or is freshly pressed.
    assign paint_go = Draw && in_x && in_y &&
                      (!last_vld_q || (cur_x != last_x_q) || (cur_y != last_y_q) || !draw_prev_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        last_x_d   = last_x_q;
        last_y_d   = last_y_q;
        last_vld_d = last_vld_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        clr_pend_d = clr_pend_q | Clear;
        we         = 1'b0;
        nb_ok      = 1'b0;
        clr_col    = 1'b0;
        wr_x       = cx_q;
        wr_y       = cy_q;
        wr_data    = INK;
        case (state_q)
            IDLE: begin
                if (clr_pend_q || Clear) begin
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    clr_pend_d = 1'b0;
                end else if (Stream_start) begin
                    state_d = STREAM;
                    sx_d    = '0;
                    sy_d    = '0;
                end else if (paint_go) begin
                    state_d = PAINT_C;
                    cx_d    = cur_x;
                    cy_d    = cur_y;
                end
            end
            PAINT_C: begin
                we         = 1'b1;
                last_x_d   = cx_q;
                last_y_d   = cy_q;
                last_vld_d = 1'b1;
                cnt_d      = '0;
                state_d    = PAINT_N;
            end
            PAINT_N: begin
                // Neighbour order W, E, N, S; off-canvas ones burn their cycle unwritten.
                case (cnt_q[1:0])
                    2'd0: begin wr_x = cx_q - 5'd1; nb_ok = (cx_q != '0);      end
                    2'd1: begin wr_x = cx_q + 5'd1; nb_ok = (cx_q != CELL_MAX); end
                    2'd2: begin wr_y = cy_q - 5'd1; nb_ok = (cy_q != '0);      end
                    2'd3: begin wr_y = cy_q + 5'd1; nb_ok = (cy_q != CELL_MAX); end
                endcase
                we      = nb_ok;
                wr_data = sat_spread(canvas_q[wr_x][wr_y]);
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q[1:0] == 2'd3) state_d = IDLE;
            end
            CLEAR: begin
                clr_col = 1'b1;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == CELL_MAX) begin
                    state_d    = IDLE;
                    last_vld_d = 1'b0;
                end
            end
            STREAM: begin
                if (Pix_ready) begin
                    if (Pix_last) begin
                        state_d = IDLE;
                    end else if (sx_q == CELL_MAX) begin
                        sx_d = '0;
                        sy_d = sy_q + 5'd1;
                    end else begin
                        sx_d = sx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            last_x_q    <= '0;
            last_y_q    <= '0;
            last_vld_q  <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            clr_pend_q  <= 1'b0;
            draw_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            last_vld_q  <= last_vld_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            clr_pend_q  <= clr_pend_d;
            draw_prev_q <= Draw;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            canvas_q <= '0;
        end else if (clr_col) begin
            canvas_q[cnt_q] <= '0;
        end else if (we) begin
            canvas_q[wr_x][wr_y] <= wr_data;
        end
    end

    assign canvas    = canvas_q;
    assign Pix_valid = (state_q == STREAM);
    assign Pix_last  = Pix_valid && (sx_q == CELL_MAX) && (sy_q == CELL_MAX);
    assign Pix_data  = Pix_valid ? canvas_q[sx_q][sy_q] : 16'h0000;
    assign Busy      = (state_q != IDLE);
endmodule

// File: tb/tb_canvas_painter.sv
// Randomized self-checking bench for canvas_painter against a cell-array model.
module tb_canvas_painter;
    localparam int N     = 28;
    localparam int PX    = 14;
    localparam int OX    = 199;
    localparam int OY    = 43;
    localparam int INKV  = 16'h07F8;
    localparam int SPRV  = 16'h0200;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset_n;
    logic [9:0]  BallX, BallY;
    logic        Draw, Clear, Stream_start, Pix_ready;
    logic [N-1:0][N-1:0][15:0] canvas;
    logic [15:0] Pix_data;
    logic        Pix_valid, Pix_last, Busy;

    int checks = 0;
    int errors = 0;
    int model [N][N];
    int diff_x, diff_y;

    canvas_painter dut (
        .Clk(Clk), .Reset_n(Reset_n), .BallX(BallX), .BallY(BallY),
        .Draw(Draw), .Clear(Clear), .Stream_start(Stream_start), .Pix_ready(Pix_ready),
        .canvas(canvas), .Pix_data(Pix_data), .Pix_valid(Pix_valid),
        .Pix_last(Pix_last), .Busy(Busy)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic void model_zero();
        for (int x = 0; x < N; x++)
            for (int y = 0; y < N; y++) model[x][y] = 0;
    endfunction

    function automatic void model_paint(input int cx, input int cy);
        int dx [4] = '{-1, 1, 0, 0};
        int dy [4] = '{0, 0, -1, 1};
        model[cx][cy] = INKV;
        for (int k = 0; k < 4; k++) begin
            int nx = cx + dx[k];
            int ny = cy + dy[k];
            if (nx >= 0 && nx < N && ny >= 0 && ny < N) begin
                model[nx][ny] = model[nx][ny] + SPRV;
                if (model[nx][ny] > INKV) model[nx][ny] = INKV;
            end
        end
    endfunction

    function automatic bit cell_of(input int p, input int org, output int c);
        c = 0;
        if (p < org) return 1'b0;
        c = (p - org) / PX;
        return c < N;
    endfunction

    function automatic int canvas_diffs();
        int n = 0;
        for (int x = 0; x < N; x++)
            for (int y = 0; y < N; y++)
                if (canvas[x][y] !== 16'(model[x][y])) begin
                    if (n == 0) begin diff_x = x; diff_y = y; end
                    n++;
                end
        return n;
    endfunction

    task automatic paint(input int px, input int py, input bit hold, output int busy_cycles);
        BallX = 10'(px);
        BallY = 10'(py);
        Draw  = 1'b1;
        tick();
        if (!hold) Draw = 1'b0;
        busy_cycles = 0;
        while (Busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            tick();
        end
        if (!hold) tick();
    endtask

    task automatic test_reset();
        int d;
        Reset_n = 1'b0; BallX = '0; BallY = '0; Draw = 0; Clear = 0;
        Stream_start = 0; Pix_ready = 0;
        model_zero();
        repeat (3) tick();
        checks++;
        if ({Busy, Pix_valid, Pix_last} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl busy/valid/last=%b%b%b want 000", Busy, Pix_valid, Pix_last);
        end
        checks++;
        if (Pix_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data Pix_data=%h want 0000", Pix_data);
        end
        d = canvas_diffs();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL reset_canvas %0d cells nonzero, first [%0d][%0d]=%h", d, diff_x, diff_y,
                     canvas[diff_x][diff_y]);
        end
        #2 Reset_n = 1'b1;
        tick();
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release Busy=%b want 0", Busy);
        end
    endtask

    task automatic test_paint_centre();
        int bc, d;
        paint(272, 142, 1'b0, bc);
        model_paint(5, 7);
        checks++;
        if (bc !== 5) begin
            errors++;
            $display("FAIL centre_busy cycles=%0d want 5", bc);
        end
        checks++;
        if (canvas[5][7] !== 16'h07F8 || canvas[4][7] !== 16'h0200 || canvas[5][8] !== 16'h0200) begin
            errors++;
            $display("FAIL centre_cells [5][7]=%h [4][7]=%h [5][8]=%h want 07f8 0200 0200",
                     canvas[5][7], canvas[4][7], canvas[5][8]);
        end
        d = canvas_diffs();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL centre_canvas %0d diffs, first [%0d][%0d]=%h want %h", d, diff_x, diff_y,
                     canvas[diff_x][diff_y], model[diff_x][diff_y]);
        end
    endtask

    task automatic test_corner();
        int bc, d;
        paint(199, 43, 1'b0, bc);
        model_paint(0, 0);
        checks++;
        if (bc !== 5) begin
            errors++;
            $display("FAIL corner_busy cycles=%0d want 5", bc);
        end
        d = canvas_diffs();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL corner_canvas %0d diffs, first [%0d][%0d]=%h want %h", d, diff_x, diff_y,
                     canvas[diff_x][diff_y], model[diff_x][diff_y]);
        end
    endtask

    task automatic test_saturation();
        int bc, hold_busy, d;
        paint(272, 142, 1'b1, bc);
        model_paint(5, 7);
        checks++;
        if (bc !== 5) begin
            errors++;
            $display("FAIL sat_first_busy cycles=%0d want 5", bc);
        end
        paint(272, 155, 1'b1, bc);
        model_paint(5, 8);
        checks++;
        if (bc !== 5) begin
            errors++;
            $display("FAIL sat_drag_busy cycles=%0d want 5", bc);
        end
        hold_busy = 0;
        repeat (12) begin
            if (Busy === 1'b1) hold_busy++;
            tick();
        end
        Draw = 1'b0;
        tick();
        checks++;
        if (hold_busy !== 0) begin
            errors++;
            $display("FAIL sat_hold_repaint busy_cycles=%0d want 0", hold_busy);
        end
        checks++;
        if (canvas[5][7] !== 16'h07F8 || canvas[5][9] !== 16'h0200) begin
            errors++;
            $display("FAIL sat_cells [5][7]=%h [5][9]=%h want 07f8 0200", canvas[5][7], canvas[5][9]);
        end
        d = canvas_diffs();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL sat_canvas %0d diffs, first [%0d][%0d]=%h want %h", d, diff_x, diff_y,
                     canvas[diff_x][diff_y], model[diff_x][diff_y]);
        end
    endtask

    task automatic test_random_paint(input int count);
        int fx [6] = '{198, 590, 591, 400, 199, 300};
        int fy [6] = '{100, 434, 100, 435, 42, 434};
        int px, py, cx, cy, bc, d, want;
        bit ix, iy;
        for (int i = 0; i < count; i++) begin
            if (i < 6) begin
                px = fx[i]; py = fy[i];
            end else begin
                px = int'($urandom_range(150, 640));
                py = int'($urandom_range(0, 480));
            end
            ix = cell_of(px, OX, cx);
            iy = cell_of(py, OY, cy);
            want = (ix && iy) ? 5 : 0;
            paint(px, py, 1'b0, bc);
            if (ix && iy) model_paint(cx, cy);
            checks++;
            if (bc !== want) begin
                errors++;
                $display("FAIL rand_busy (%0d,%0d) cycles=%0d want %0d", px, py, bc, want);
            end
        end
        d = canvas_diffs();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL rand_canvas %0d diffs, first [%0d][%0d]=%h want %h", d, diff_x, diff_y,
                     canvas[diff_x][diff_y], model[diff_x][diff_y]);
        end
    endtask

    // Runs one whole stream with random backpressure; optionally pulses Clear at beat 100
    // and holds the pen down on the canvas throughout.
    task automatic run_stream(input bit pulse_clear, output int beats, output int bad);
        int cyc = 0;
        bit stalled = 0;
        bit pulsed = 0;
        logic [15:0] held_data;
        logic held_last;
        logic [15:0] exp_d;
        bit rdy;
        beats = 0; bad = 0;
        held_data = '0; held_last = 0;
        Stream_start = 1'b1;
        tick();
        Stream_start = 1'b0;
        BallX = 10'd300; BallY = 10'd200; Draw = 1'b1;
        while (beats < 784 && cyc < 6000) begin
            cyc++;
            Clear = 1'b0;
            if (pulse_clear && !pulsed && beats == 100) begin
                Clear = 1'b1;
                pulsed = 1;
            end
            if (stalled && (Pix_data !== held_data || Pix_last !== held_last || Pix_valid !== 1'b1)) begin
                bad++;
                if (bad < 5)
                    $display("FAIL stream_hold beat %0d data=%h last=%b want %h %b",
                             beats, Pix_data, Pix_last, held_data, held_last);
            end
            rdy = 1'($urandom_range(0, 1));
            Pix_ready = rdy;
            if (rdy) begin
                exp_d = 16'(model[beats % N][beats / N]);
                if (Pix_valid !== 1'b1 || Pix_data !== exp_d || Pix_last !== (beats == 783)) begin
                    bad++;
                    if (bad < 5)
                        $display("FAIL stream_beat %0d valid=%b data=%h last=%b want 1 %h %b",
                                 beats, Pix_valid, Pix_data, Pix_last, exp_d, beats == 783);
                end
                beats++;
                stalled = 0;
            end else begin
                held_data = Pix_data;
                held_last = Pix_last;
                stalled = 1;
            end
            tick();
        end
        Pix_ready = 1'b0;
        Draw = 1'b0;
        Clear = 1'b0;
    endtask

    task automatic test_stream_backpressure();
        int beats, bad, d;
        run_stream(1'b0, beats, bad);
        checks++;
        if (beats !== 784) begin
            errors++;
            $display("FAIL stream_count transfers=%0d want 784", beats);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stream_data %0d bad beats want 0", bad);
        end
        checks++;
        if (Busy !== 1'b0 || Pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end Busy=%b Pix_valid=%b want 0 0", Busy, Pix_valid);
        end
        tick();
        d = canvas_diffs();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL stream_canvas %0d diffs, first [%0d][%0d]=%h want %h", d, diff_x, diff_y,
                     canvas[diff_x][diff_y], model[diff_x][diff_y]);
        end
    endtask

    task automatic test_deferred_clear();
        int beats, bad, w, cc, d;
        run_stream(1'b1, beats, bad);
        checks++;
        if (beats !== 784 || bad !== 0) begin
            errors++;
            $display("FAIL dclr_stream transfers=%0d bad=%0d want 784 0", beats, bad);
        end
        w = 0;
        while (Busy !== 1'b1 && w < 5) begin w++; tick(); end
        cc = 0;
        while (Busy === 1'b1 && cc < 60) begin cc++; tick(); end
        model_zero();
        checks++;
        if (cc !== 28) begin
            errors++;
            $display("FAIL dclr_cycles clear busy=%0d want 28", cc);
        end
        d = canvas_diffs();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL dclr_canvas %0d nonzero, first [%0d][%0d]=%h", d, diff_x, diff_y,
                     canvas[diff_x][diff_y]);
        end
    endtask

    task automatic test_async_reset();
        int bc, beats, cyc, d;
        paint(272, 142, 1'b0, bc);
        paint(450, 300, 1'b0, bc);
        Stream_start = 1'b1;
        tick();
        Stream_start = 1'b0;
        Pix_ready = 1'b1;
        beats = 0; cyc = 0;
        while (beats < 300 && cyc < 1000) begin
            if (Pix_valid === 1'b1) beats++;
            cyc++;
            tick();
        end
        #2 Reset_n = 1'b0;
        #1;
        model_zero();
        checks++;
        if (Pix_valid !== 1'b0 || Busy !== 1'b0 || Pix_data !== 16'h0000) begin
            errors++;
            $display("FAIL areset_ctrl valid=%b busy=%b data=%h want 0 0 0000", Pix_valid, Busy, Pix_data);
        end
        d = canvas_diffs();
        checks++;
        if (d !== 0) begin
            errors++;
            $display("FAIL areset_canvas %0d nonzero, first [%0d][%0d]=%h", d, diff_x, diff_y,
                     canvas[diff_x][diff_y]);
        end
        #2 Reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (Busy !== 1'b0 || Pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle Busy=%b Pix_valid=%b want 0 0", Busy, Pix_valid);
        end
        Pix_ready = 1'b0;
        paint(272, 142, 1'b0, bc);
        model_paint(5, 7);
        d = canvas_diffs();
        checks++;
        if (bc !== 5 || d !== 0) begin
            errors++;
            $display("FAIL areset_repaint busy=%0d diffs=%0d want 5 0", bc, d);
        end
    endtask

    initial begin
        test_reset();
        test_paint_centre();
        test_corner();
        test_saturation();
        test_random_paint(30);
        test_stream_backpressure();
        test_deferred_clear();
        test_random_paint(12);
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
